// File: rtl/dil_bfly_byte_sequencer.sv
// Byte-wide command/result sequencer around the butterfly core: collects a 10-byte
// command frame, fires one bf_validi strobe, waits for bf_valido, streams a 7-byte result.
module dil_bfly_byte_sequencer #(
  parameter int DW      = 24,
  parameter int TIMEOUT = 63
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sync_clr,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [2:0]    bf_mode,
  output logic          bf_validi,
  output logic [DW-1:0] bf_aj,
  output logic [DW-1:0] bf_ajlen,
  output logic [DW-1:0] bf_zeta,
  input  logic [DW-1:0] bf_bj,
  input  logic [DW-1:0] bf_bjlen,
  input  logic          bf_valido,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
);

  typedef enum logic [1:0] {S_RECV, S_ISSUE, S_WAIT, S_SEND} state_t;

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic [2:0]    r_mode_asm;
  logic [63:0]   r_asm;
  logic [7:0]    r_wait;
  logic [2:0]    r_idx;
  logic          r_ok;
  logic          r_to;
  logic [DW-1:0] r_bj;
  logic [DW-1:0] r_bjlen;

  logic          w_in_fire;
  logic          w_out_fire;
  logic [71:0]   w_frame;
  logic [7:0]    w_wait_inc;
  logic [2:0]    w_next_idx;
  logic [7:0]    w_next_byte;

  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;
  // b1..b8 live in r_asm; the 10th byte completes the frame on the fly.
  assign w_frame    = {r_asm, in_data};
  assign w_wait_inc = r_wait + 8'd1;
  assign w_next_idx = r_idx + 3'd1;

  always_comb begin
    w_next_byte = {6'b0, r_to, r_ok};
    case (w_next_idx)
      3'd1:    w_next_byte = r_bj[23:16];
      3'd2:    w_next_byte = r_bj[15:8];
      3'd3:    w_next_byte = r_bj[7:0];
      3'd4:    w_next_byte = r_bjlen[23:16];
      3'd5:    w_next_byte = r_bjlen[15:8];
      3'd6:    w_next_byte = r_bjlen[7:0];
      default: w_next_byte = {6'b0, r_to, r_ok};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_RECV;
      r_cnt      <= 4'd0;
      r_mode_asm <= 3'd0;
      r_asm      <= 64'd0;
      r_wait     <= 8'd0;
      r_idx      <= 3'd0;
      r_ok       <= 1'b0;
      r_to       <= 1'b0;
      r_bj       <= '0;
      r_bjlen    <= '0;
      in_ready   <= 1'b1;
      bf_mode    <= 3'd0;
      bf_validi  <= 1'b0;
      bf_aj      <= '0;
      bf_ajlen   <= '0;
      bf_zeta    <= '0;
      out_data   <= 8'd0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
    end else if (sync_clr) begin
      // Abort whatever is in flight; the bf_* data registers deliberately survive.
      r_state   <= S_RECV;
      r_cnt     <= 4'd0;
      r_wait    <= 8'd0;
      r_idx     <= 3'd0;
      r_ok      <= 1'b0;
      r_to      <= 1'b0;
      in_ready  <= 1'b1;
      bf_validi <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        S_RECV: begin
          if (w_in_fire) begin
            if (r_cnt == 4'd9) begin
              bf_mode   <= r_mode_asm;
              bf_aj     <= w_frame[71:48];
              bf_ajlen  <= w_frame[47:24];
              bf_zeta   <= w_frame[23:0];
              r_cnt     <= 4'd0;
              r_ok      <= 1'b0;
              r_to      <= 1'b0;
              in_ready  <= 1'b0;
              bf_validi <= 1'b1;
              busy      <= 1'b1;
              r_state   <= S_ISSUE;
            end else begin
              if (r_cnt == 4'd0) r_mode_asm <= in_data[2:0];
              else               r_asm      <= {r_asm[55:0], in_data};
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        S_ISSUE: begin
          bf_validi <= 1'b0;
          r_wait    <= 8'd0;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          r_wait <= w_wait_inc;
          // A result arriving on the timeout cycle is still taken as a good result.
          if (bf_valido) begin
            r_bj      <= bf_bj;
            r_bjlen   <= bf_bjlen;
            r_ok      <= 1'b1;
            r_idx     <= 3'd0;
            out_data  <= 8'h01;
            out_valid <= 1'b1;
            r_state   <= S_SEND;
          end else if (w_wait_inc == 8'(TIMEOUT)) begin
            r_bj      <= '0;
            r_bjlen   <= '0;
            r_to      <= 1'b1;
            r_idx     <= 3'd0;
            out_data  <= 8'h02;
            out_valid <= 1'b1;
            r_state   <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_out_fire) begin
            if (r_idx == 3'd6) begin
              r_idx     <= 3'd0;
              r_cnt     <= 4'd0;
              out_valid <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
              r_state   <= S_RECV;
            end else begin
              r_idx    <= w_next_idx;
              out_data <= w_next_byte;
            end
          end
        end
        default: r_state <= S_RECV;
      endcase
    end
  end

endmodule

// File: tb/tb_dil_bfly_byte_sequencer.sv
// Scoreboard bench for dil_bfly_byte_sequencer with a fixed-latency (L=3) core stub.
module tb_dil_bfly_byte_sequencer;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sync_clr = 1'b0;
  logic [7:0]    in_data = 8'd0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    bf_mode;
  logic          bf_validi;
  logic [DW-1:0] bf_aj, bf_ajlen, bf_zeta;
  logic [DW-1:0] bf_bj, bf_bjlen;
  logic          bf_valido;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          busy;

  dil_bfly_byte_sequencer #(.DW(DW), .TIMEOUT(63)) dut (
    .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .bf_mode(bf_mode), .bf_validi(bf_validi), .bf_aj(bf_aj), .bf_ajlen(bf_ajlen),
    .bf_zeta(bf_zeta), .bf_bj(bf_bj), .bf_bjlen(bf_bjlen), .bf_valido(bf_valido),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Core stub: result appears 3 cycles after the strobe
  logic [2:0]    stub_pipe = 3'd0;
  logic [DW-1:0] stub_bj = '0, stub_bjlen = '0;
  logic          stub_en = 1'b1;
  logic          stray_valido = 1'b0;
  always @(posedge clk) begin
    stub_pipe <= {stub_pipe[1:0], bf_validi};
    if (bf_validi) begin
      stub_bj    <= bf_aj + bf_ajlen;
      stub_bjlen <= bf_aj - bf_ajlen;
    end
  end
  assign bf_valido = (stub_pipe[2] & stub_en) | stray_valido;
  assign bf_bj     = stub_bj;
  assign bf_bjlen  = stub_bjlen;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [2:0]  exp_mode;
  logic [23:0] exp_aj, exp_ajlen;
  int n_issue = 0, n_xfer = 0, issue_cyc = 0, first_ov_cyc = 0;
  int rdy_mode = 0, rdy_limit = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on each output transfer, checks issue fields and hold stability
  initial begin
    logic       held_pending = 1'b0;
    logic [7:0] held_data = 8'd0;
    logic       prev_validi = 1'b0;
    logic       prev_ov = 1'b0;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held_pending = 1'b0;
        prev_validi  = 1'b0;
        prev_ov      = 1'b0;
      end else begin
        if (held_pending && out_valid) chk("hold_stable", out_data, held_data);
        if (bf_validi) begin
          chk("validi_one_cycle", prev_validi, 0);
          chk("issue_mode", bf_mode, exp_mode);
          chk("issue_aj", bf_aj, exp_aj);
          chk("issue_ajlen", bf_ajlen, exp_ajlen);
          n_issue++;
          issue_cyc = cyc;
          $display("issue mode=%0d aj=%06h ajlen=%06h cyc=%0d", bf_mode, bf_aj, bf_ajlen, cyc);
        end
        if (out_valid && !prev_ov) first_ov_cyc = cyc;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_byte: got %02h expected none", out_data);
          end else begin
            e = exp_q.pop_front();
            $display("out byte %02h expected %02h", out_data, e);
            chk("out_byte", out_data, e);
          end
          n_xfer++;
        end
        held_pending = out_valid && !out_ready;
        held_data    = out_data;
        prev_validi  = bf_validi;
        prev_ov      = out_valid;
      end
    end
  end

  // out_ready driver: 0 always-on, 1 one-on/two-off, 2 on until rdy_limit transfers
  initial begin
    int ph = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: begin out_ready = (ph == 0); ph = (ph + 1) % 3; end
        2: out_ready = (n_xfer < rdy_limit);
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int  g;
    logic acc;
    int  k;
    g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    in_valid = 1'b0;
    repeat (g) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = b;
    acc = 1'b0;
    for (k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL byte_accept: got in_ready=0 for 200 cycles expected acceptance");
    end
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [79:0] f, input int n, input int gap_max);
    for (int i = 0; i < n; i++) send_byte(f[79-8*i -: 8], gap_max);
  endtask

  task automatic push_exp(input logic [55:0] r);
    for (int i = 0; i < 7; i++) exp_q.push_back(r[55-8*i -: 8]);
  endtask

  task automatic wait_done(input string name);
    int k;
    for (k = 0; k < 400; k++) begin
      if (exp_q.size() == 0 && !busy && !out_valid) break;
      @(posedge clk);
      #1;
    end
    if (k == 400) begin
      checks++;
      failures++;
      $display("FAIL %s_done: got %0d bytes pending expected 0 within 400 cycles", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic set_exp(input logic [2:0] m, input logic [23:0] a, input logic [23:0] al);
    exp_mode = m; exp_aj = a; exp_ajlen = al;
  endtask

  localparam logic [79:0] T1_FRAME = 80'h01_000005_000003_000001;
  localparam logic [55:0] T1_RES   = 56'h01_000008_000002;

  initial begin
    int base;
    int k;
    // Reset values
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_validi", bf_validi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_aj", bf_aj, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // T1 nominal
    set_exp(3'd1, 24'h5, 24'h3);
    push_exp(T1_RES);
    base = n_issue;
    send_frame(T1_FRAME, 10, 0);
    wait_done("t1");
    chk("t1_issues", n_issue - base, 1);
    chk("t1_latency", first_ov_cyc - issue_cyc, 4);

    // T2 backpressure and gapped input
    rdy_mode = 1;
    push_exp(T1_RES);
    send_frame(T1_FRAME, 10, 2);
    wait_done("t2");
    rdy_mode = 0;

    // T3 timeout
    stub_en = 1'b0;
    push_exp(56'h02_000000_000000);
    send_frame(T1_FRAME, 10, 0);
    wait_done("t3");
    chk("t3_timeout_latency", first_ov_cyc - issue_cyc, 64);
    stub_en = 1'b1;

    // T4 sync_clr after 6 bytes
    base = n_issue;
    send_frame(T1_FRAME, 6, 0);
    sync_clr = 1'b1;
    @(posedge clk); #1;
    sync_clr = 1'b0;
    chk("t4_in_ready", in_ready, 1);
    chk("t4_busy", busy, 0);
    chk("t4_out_valid", out_valid, 0);
    push_exp(T1_RES);
    send_frame(T1_FRAME, 10, 0);
    wait_done("t4");
    chk("t4_issues", n_issue - base, 1);

    // T5 async reset while the third result byte is presented
    rdy_limit = n_xfer + 2;
    rdy_mode  = 2;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h00);
    send_frame(T1_FRAME, 10, 0);
    for (k = 0; k < 200; k++) begin
      if (n_xfer == rdy_limit && out_valid) break;
      @(posedge clk); #1;
    end
    chk("t5_reached_byte3", n_xfer - rdy_limit, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_out_valid", out_valid, 0);
    chk("t5_in_ready", in_ready, 1);
    chk("t5_busy", busy, 0);
    chk("t5_aj_cleared", bf_aj, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rdy_mode = 0;
    chk("t5_queue_empty", exp_q.size(), 0);
    push_exp(T1_RES);
    send_frame(T1_FRAME, 10, 0);
    wait_done("t5");

    // T6 stray valido during RECV, then T1, then wrap-around operands
    base = n_issue;
    send_frame(T1_FRAME, 3, 0);
    stray_valido = 1'b1;
    @(posedge clk); #1;
    stray_valido = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("t6_stray_out_valid", out_valid, 0);
    chk("t6_stray_busy", busy, 0);
    push_exp(T1_RES);
    send_frame({T1_FRAME[55:0], 24'h0}, 7, 0);
    wait_done("t6");
    set_exp(3'd2, 24'hFFFFFF, 24'h000001);
    push_exp(56'h01_000000_FFFFFE);
    send_frame(80'h02_FFFFFF_000001_000000, 10, 0);
    wait_done("t6_wrap");
    chk("t6_issues", n_issue - base, 2);

    repeat (3) begin @(posedge clk); #1; end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
